// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD read path: FSM states, pin-vector
// bit positions and default HD44780 read timing in 100 MHz clock cycles.
package lcd_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitGnt,
      StNibHi,
      StNibLo,
      StDone
   } rd_state_e;

   typedef enum logic [1:0] {
      NbIdle,
      NbSetup,
      NbHigh,
      NbLow
   } nib_state_e;

   // Bit positions inside the registered pin vector {DB_OE, RW, RS}
   localparam int unsigned PIN_RS = 0;
   localparam int unsigned PIN_RW = 1;
   localparam int unsigned PIN_OE = 2;
   localparam logic [2:0]  PINS_IDLE = 3'b100;

   localparam int unsigned BF_BIT = 7;

   localparam int unsigned T_SETUP_DEF  = 4;
   localparam int unsigned T_E_HIGH_DEF = 30;
   localparam int unsigned T_E_LOW_DEF  = 60;
   localparam int unsigned POLL_MAX_DEF = 1023;
   localparam int unsigned POLL_W_DEF   = 10;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_nibble_reader.sv
// Generates one E pulse (optional RS/RW setup, E high, E low) and captures
// DB7..DB4 through a 2-flop synchronizer on the last E-high cycle.
module lcd_nibble_reader
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP  = T_SETUP_DEF,
   parameter int unsigned T_E_HIGH = T_E_HIGH_DEF,
   parameter int unsigned T_E_LOW  = T_E_LOW_DEF
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic       I_START,
   input  logic       I_SETUP,
   input  logic [3:0] I_LCD_DB,
   output logic       O_LCD_E,
   output logic [3:0] O_NIBBLE,
   output logic       O_DONE
);

   localparam int unsigned CNT_W = $clog2(max3(T_SETUP, T_E_HIGH, T_E_LOW) + 1);

   nib_state_e       st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             e_q, e_d;
   logic [3:0]       nib_q, nib_d;
   logic [3:0]       db_meta_q, db_sync_q;
   logic             setup_last, high_last, low_last;

   assign setup_last = (cnt_q == CNT_W'(T_SETUP - 1));
   assign high_last  = (cnt_q == CNT_W'(T_E_HIGH - 1));
   assign low_last   = (cnt_q == CNT_W'(T_E_LOW - 1));

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         st_q      <= NbIdle;
         cnt_q     <= '0;
         e_q       <= 1'b0;
         nib_q     <= '0;
         db_meta_q <= '0;
         db_sync_q <= '0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         e_q       <= e_d;
         nib_q     <= nib_d;
         db_meta_q <= I_LCD_DB;
         db_sync_q <= db_meta_q;
      end
   end

   // A start arriving on the last E-low cycle chains straight into the next pulse
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q + 1'b1;
      unique case (st_q)
         NbIdle: begin
            cnt_d = '0;
            if (I_START) st_d = I_SETUP ? NbSetup : NbHigh;
         end
         NbSetup: begin
            if (setup_last) begin
               cnt_d = '0;
               st_d  = NbHigh;
            end
         end
         NbHigh: begin
            if (high_last) begin
               cnt_d = '0;
               st_d  = NbLow;
            end
         end
         NbLow: begin
            if (low_last) begin
               cnt_d = '0;
               if (I_START) st_d = I_SETUP ? NbSetup : NbHigh;
               else         st_d = NbIdle;
            end
         end
         default: begin
            cnt_d = '0;
            st_d  = NbIdle;
         end
      endcase
   end

   always_comb begin
      e_d   = (st_d == NbHigh);
      nib_d = nib_q;
      if ((st_q == NbHigh) && high_last) nib_d = db_sync_q;
   end

   assign O_LCD_E  = e_q;
   assign O_NIBBLE = nib_q;
   assign O_DONE   = (st_q == NbLow) && low_last;

endmodule

// File: rtl/lcd_readback.sv
// HD44780 4-bit read engine: arbitrates for the LCD pins, reads status or data
// as two nibbles and optionally polls the busy flag until it clears.
module lcd_readback
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP  = T_SETUP_DEF,
   parameter int unsigned T_E_HIGH = T_E_HIGH_DEF,
   parameter int unsigned T_E_LOW  = T_E_LOW_DEF,
   parameter int unsigned POLL_MAX = POLL_MAX_DEF,
   parameter int unsigned POLL_W   = POLL_W_DEF
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic       I_READ_START,
   input  logic       I_READ_RS,
   input  logic       I_POLL_BUSY,
   output logic [7:0] O_READ_DATA,
   output logic       O_READ_DONE,
   output logic       O_TIMEOUT,
   output logic       O_BUSY,
   output logic       O_BUS_REQ,
   input  logic       I_BUS_GRANT,
   output logic       O_LCD_RS,
   output logic       O_LCD_RW,
   output logic       O_LCD_E,
   output logic       O_LCD_DB_OE,
   input  logic [3:0] I_LCD_DB
);

   rd_state_e         st_q, st_d;
   logic              busy_q, busy_d;
   logic              req_q, req_d;
   logic [2:0]        pins_q, pins_d;
   logic              rs_lat_q, rs_lat_d;
   logic              poll_q, poll_d;
   logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
   logic [7:0]        byte_q, byte_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              done_q, done_d;
   logic              to_q, to_d;

   logic              accept, granted, poll_again, finish;
   logic              nib_start, nib_setup, nib_done;
   logic [3:0]        nibble;

   assign accept     = (st_q == StIdle) && I_READ_START;
   assign granted    = (st_q == StWaitGnt) && I_BUS_GRANT;
   assign poll_again = poll_q && byte_q[BF_BIT] && (poll_cnt_q < POLL_W'(POLL_MAX));
   assign finish     = (st_q == StNibLo) && nib_done && !poll_again;
   assign nib_start  = granted || ((st_q == StNibHi) && nib_done) ||
                       ((st_q == StNibLo) && nib_done && poll_again);
   // Only the low nibble follows directly on EL_MID; every read begins with SETUP
   assign nib_setup  = (st_q != StNibHi);

   lcd_nibble_reader #(
      .T_SETUP  (T_SETUP),
      .T_E_HIGH (T_E_HIGH),
      .T_E_LOW  (T_E_LOW)
   ) u_nibble (
      .I_CLK    (I_CLK),
      .I_RST    (I_RST),
      .I_START  (nib_start),
      .I_SETUP  (nib_setup),
      .I_LCD_DB (I_LCD_DB),
      .O_LCD_E  (O_LCD_E),
      .O_NIBBLE (nibble),
      .O_DONE   (nib_done)
   );

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         st_q       <= StIdle;
         busy_q     <= 1'b0;
         req_q      <= 1'b0;
         pins_q     <= PINS_IDLE;
         rs_lat_q   <= 1'b0;
         poll_q     <= 1'b0;
         poll_cnt_q <= '0;
         byte_q     <= '0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
         to_q       <= 1'b0;
      end else begin
         st_q       <= st_d;
         busy_q     <= busy_d;
         req_q      <= req_d;
         pins_q     <= pins_d;
         rs_lat_q   <= rs_lat_d;
         poll_q     <= poll_d;
         poll_cnt_q <= poll_cnt_d;
         byte_q     <= byte_d;
         rd_data_q  <= rd_data_d;
         done_q     <= done_d;
         to_q       <= to_d;
      end
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         StIdle:    if (I_READ_START) st_d = StWaitGnt;
         StWaitGnt: if (I_BUS_GRANT)  st_d = StNibHi;
         StNibHi:   if (nib_done)     st_d = StNibLo;
         StNibLo:   if (nib_done)     st_d = poll_again ? StNibHi : StDone;
         StDone:                      st_d = StIdle;
         default:                     st_d = StIdle;
      endcase
   end

   always_comb begin
      busy_d     = busy_q;
      req_d      = req_q;
      pins_d     = pins_q;
      rs_lat_d   = rs_lat_q;
      poll_d     = poll_q;
      poll_cnt_d = poll_cnt_q;
      byte_d     = byte_q;
      rd_data_d  = rd_data_q;
      done_d     = finish;
      to_d       = finish && poll_q && byte_q[BF_BIT];

      if (accept) begin
         busy_d     = 1'b1;
         req_d      = 1'b1;
         rs_lat_d   = I_READ_RS;
         poll_d     = I_POLL_BUSY & ~I_READ_RS;
         poll_cnt_d = '0;
      end
      if (granted) begin
         pins_d[PIN_RS] = rs_lat_q;
         pins_d[PIN_RW] = 1'b1;
         pins_d[PIN_OE] = 1'b0;
      end
      if ((st_q == StNibHi) && nib_done) byte_d[7:4] = nibble;
      if ((st_q == StNibLo) && nib_done) begin
         byte_d[3:0] = nibble;
         if (poll_again) poll_cnt_d = poll_cnt_q + 1'b1;
      end
      if (finish) rd_data_d = {byte_q[7:4], nibble};
      if (st_q == StDone) begin
         busy_d         = 1'b0;
         req_d          = 1'b0;
         pins_d[PIN_RW] = 1'b0;
         pins_d[PIN_OE] = 1'b1;
      end
   end

   assign O_READ_DATA = rd_data_q;
   assign O_READ_DONE = done_q;
   assign O_TIMEOUT   = to_q;
   assign O_BUSY      = busy_q;
   assign O_BUS_REQ   = req_q;
   assign O_LCD_RS    = pins_q[PIN_RS];
   assign O_LCD_RW    = pins_q[PIN_RW];
   assign O_LCD_DB_OE = pins_q[PIN_OE];

endmodule

// File: tb/tb_lcd_readback.sv
// Randomized bench for lcd_readback: an LCD pad model, a grant arbiter and a
// per-cycle monitor compared against a transaction-level expectation.
module tb_lcd_readback;

   localparam int unsigned T_SETUP  = 4;
   localparam int unsigned T_E_HIGH = 30;
   localparam int unsigned T_E_LOW  = 60;
   localparam int unsigned POLL_MAX = 3;
   localparam int unsigned POLL_W   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       rd_rs = 1'b0;
   logic       poll = 1'b0;
   logic       gnt = 1'b0;
   logic [3:0] lcd_db;
   logic [7:0] rd_data;
   logic       rd_done, tmo, busy, req, lcd_rs, lcd_rw, lcd_e, lcd_oe;

   int         checks = 0;
   int         errors = 0;

   // Transaction expectation
   logic [7:0] bytes [6];
   int         exp_reads = 0;
   logic [7:0] exp_data = '0;
   logic       exp_to = 1'b0;
   logic       exp_rs = 1'b0;

   // LCD pad model: one nibble per E pulse, 0xF whenever E is low
   logic [3:0] lcd_q [$];
   logic [3:0] nib_cur = 4'hF;
   assign lcd_db = lcd_e ? nib_cur : 4'hF;

   // Monitor state
   bit         mon_en = 1'b0;
   logic       exp_busy = 1'b0;
   logic       e_prev = 1'b0;
   logic       aborted = 1'b0;
   logic       gnt_owned = 1'b0;
   int         hi_len = 0;
   int         lo_len = 0;
   int         pulses = 0;
   int         done_cnt = 0;
   int         gnt_delay = 5;
   int         gcnt = 0;

   lcd_readback #(
      .T_SETUP  (T_SETUP),
      .T_E_HIGH (T_E_HIGH),
      .T_E_LOW  (T_E_LOW),
      .POLL_MAX (POLL_MAX),
      .POLL_W   (POLL_W)
   ) dut (
      .I_CLK        (clk),
      .I_RST        (rst),
      .I_READ_START (start),
      .I_READ_RS    (rd_rs),
      .I_POLL_BUSY  (poll),
      .O_READ_DATA  (rd_data),
      .O_READ_DONE  (rd_done),
      .O_TIMEOUT    (tmo),
      .O_BUSY       (busy),
      .O_BUS_REQ    (req),
      .I_BUS_GRANT  (gnt),
      .O_LCD_RS     (lcd_rs),
      .O_LCD_RW     (lcd_rw),
      .O_LCD_E      (lcd_e),
      .O_LCD_DB_OE  (lcd_oe),
      .I_LCD_DB     (lcd_db)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outcome: poll only for status reads; stop at first BF=0 or after POLL_MAX+1 reads
   task automatic plan(input logic r, input logic p);
      logic pm;
      pm        = p & ~r;
      exp_rs    = r;
      exp_reads = 1;
      if (pm)
         while (bytes[exp_reads-1][7] && (exp_reads < int'(POLL_MAX) + 1)) exp_reads++;
      exp_data = bytes[exp_reads-1];
      exp_to   = pm && exp_data[7];
      lcd_q.delete();
      for (int i = 0; i < 6; i++) begin
         lcd_q.push_back(bytes[i][7:4]);
         lcd_q.push_back(bytes[i][3:0]);
      end
      nib_cur = lcd_q[0];
   endtask

   task automatic do_start(input logic r, input logic p);
      plan(r, p);
      @(posedge clk); #1;
      start = 1'b1;
      rd_rs = r;
      poll  = p;
      @(posedge clk); #1;
      start = 1'b0;
      rd_rs = 1'($urandom);
      poll  = 1'($urandom);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(posedge clk); #1;
         seen = rd_done;
      end
      if (!seen) chk(name, 32'(rd_done), 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Arbiter: grant gnt_delay cycles after request, release with request
   initial forever begin
      @(posedge clk); #1;
      if (req !== 1'b1) begin
         gnt  = 1'b0;
         gcnt = 0;
      end else if (gcnt >= gnt_delay) begin
         gnt = 1'b1;
      end else begin
         gcnt++;
      end
   end

   // Per-cycle monitor
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         assert (!(gnt_owned && req && !gnt)) else begin
            errors++;
            $error("FAIL grant_drop req %b gnt %b", req, gnt);
         end
         gnt_owned = req && (gnt_owned || gnt);

         chk("busy", 32'(busy), 32'(exp_busy));
         chk("bus_req", 32'(req), 32'(exp_busy));
         if (!exp_busy) chk("idle_pins", 32'({lcd_e, lcd_rw, lcd_oe, rd_done}), 32'h2);
         if (tmo) chk("timeout_needs_done", 32'(rd_done), 32'd1);
         if (lcd_e) begin
            chk("owned_pins", 32'({lcd_rw, lcd_oe, lcd_rs, gnt}), 32'({2'b10, exp_rs, 1'b1}));
            if (!e_prev && !aborted) begin
               if (pulses == 0) chk("setup_len", 32'(lo_len), T_SETUP);
               else if (pulses % 2 == 1) chk("el_mid_len", 32'(lo_len), T_E_LOW);
               else chk("el_end_setup_len", 32'(lo_len), T_E_LOW + T_SETUP);
               pulses++;
            end
            hi_len++;
         end else begin
            if (e_prev) begin
               if (!aborted) chk("e_high_len", 32'(hi_len), T_E_HIGH);
               hi_len = 0;
               lo_len = 0;
               if (lcd_q.size() > 0) lcd_q.delete(0);
               nib_cur = (lcd_q.size() > 0) ? lcd_q[0] : 4'hF;
            end
            if (rd_done) begin
               chk("el_end_len", 32'(lo_len), T_E_LOW);
               chk("pulses", 32'(pulses), 32'(2 * exp_reads));
               chk("read_data", 32'(rd_data), 32'(exp_data));
               chk("timeout", 32'(tmo), 32'(exp_to));
               done_cnt++;
            end
            if (lcd_rw) lo_len++;
         end
         e_prev = lcd_e;

         if (rst) begin
            exp_busy = 1'b0;
            aborted  = 1'b1;
         end else if (rd_done) begin
            exp_busy = 1'b0;
         end else if (start && !exp_busy) begin
            exp_busy = 1'b1;
            aborted  = 1'b0;
            pulses   = 0;
            lo_len   = 0;
            hi_len   = 0;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      int got;
      logic r, p;

      for (int i = 0; i < 6; i++) bytes[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'({rd_data, rd_done, tmo, busy, req, lcd_e, lcd_rw, lcd_rs, lcd_oe}),
          32'h0001);
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      idle_cycles(3);

      // Status read
      gnt_delay = 5;
      bytes[0] = 8'h3A;
      do_start(1'b0, 1'b0);
      wait_done("t1_done");
      chk("t1_data", 32'(rd_data), 32'h3A);
      chk("t1_timeout", 32'(tmo), 32'd0);
      idle_cycles(4);

      // Data read 'H'; poll request ignored because RS=1
      bytes[0] = 8'h48;
      bytes[1] = 8'hC8;
      do_start(1'b1, 1'b1);
      wait_done("t2_done");
      chk("t2_data", 32'(rd_data), 32'h48);
      chk("t2_req_in_done", 32'(req), 32'd1);
      @(posedge clk); #1;
      chk("t2_req_after", 32'(req), 32'd0);
      idle_cycles(3);

      // Busy poll clearing on the fourth read
      bytes[0] = 8'h80 | 8'($urandom_range(0, 127));
      bytes[1] = 8'h80 | 8'($urandom_range(0, 127));
      bytes[2] = 8'h80 | 8'($urandom_range(0, 127));
      bytes[3] = 8'h05;
      do_start(1'b0, 1'b1);
      wait_done("t3_done");
      chk("t3_data", 32'(rd_data), 32'h05);
      chk("t3_pulses", 32'(pulses), 32'd8);
      chk("t3_timeout", 32'(tmo), 32'd0);
      idle_cycles(3);

      // Busy flag stuck: POLL_MAX+1 reads then timeout
      for (int i = 0; i < 6; i++) bytes[i] = 8'h80 | 8'($urandom_range(0, 127));
      do_start(1'b0, 1'b1);
      wait_done("t4_done");
      chk("t4_timeout", 32'(tmo), 32'd1);
      chk("t4_bf", 32'(rd_data[7]), 32'd1);
      chk("t4_pulses", 32'(pulses), 32'd8);
      idle_cycles(3);

      // Reset in the middle of the low-nibble E pulse
      bytes[0] = 8'h9C;
      dc = done_cnt;
      do_start(1'b0, 1'b0);
      got = 0;
      for (int i = 0; i < 1000 && got == 0; i++) begin
         @(posedge clk); #1;
         if (pulses == 2) got = 1;
      end
      chk("t5_reached_eh_lo", 32'(got), 32'd1);
      idle_cycles(10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5_after_reset", 32'({lcd_e, lcd_rw, lcd_oe, req, busy}), 32'b00100);
      idle_cycles(200);
      chk("t5_no_done", 32'(done_cnt), 32'(dc));
      bytes[0] = 8'h27;
      do_start(1'b0, 1'b0);
      wait_done("t5_fresh_done");
      chk("t5_fresh_data", 32'(rd_data), 32'h27);
      idle_cycles(3);

      // Starts while busy and in DONE are ignored
      bytes[0] = 8'h61;
      dc = done_cnt;
      do_start(1'b0, 1'b0);
      idle_cycles(2);
      start = 1'b1; rd_rs = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      idle_cycles(50);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t6_done");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      idle_cycles(300);
      chk("t6_single_txn", 32'(done_cnt - dc), 32'd1);
      chk("t6_idle", 32'(busy), 32'd0);

      // Random transactions
      for (int t = 0; t < 8; t++) begin
         gnt_delay = $urandom_range(0, 8);
         r = 1'($urandom);
         p = 1'($urandom);
         for (int i = 0; i < 6; i++) begin
            bytes[i] = 8'($urandom);
            if ($urandom_range(0, 2) != 0) bytes[i][7] = 1'b1;
         end
         do_start(r, p);
         wait_done("rand_done");
         idle_cycles($urandom_range(1, 5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
